pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 118 +++++++++++
 tb/tb_pc_fetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch stage with a BOOT/RUN/HALT sequencer.
// Optional fetch-range guard enabled by defining FETCH_BOUND_CHECK_EN (adds fetch_fault).
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_3000,
  parameter int          IM_DEPTH_LOG2 = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     stall,
  input  logic                     halt,
  input  logic [1:0]               npc_sel,
  input  logic                     br_taken,
  input  logic [31:0]              reg_target,
  output logic [IM_DEPTH_LOG2-1:0] im_raddr,
  input  logic [31:0]              im_rdata,
  output logic [31:0]              instr,
  output logic                     instr_valid,
  output logic [31:0]              pc,
  output logic [31:0]              pc_plus4,
  output logic [31:0]              retired
`ifdef FETCH_BOUND_CHECK_EN
  ,
  output logic                     fetch_fault
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t      state, state_next;
  logic [31:0] npc_raw, npc, branch_offset;
  logic        load;
  logic        fault_set;

  assign pc_plus4      = pc + 32'd4;
  assign im_raddr      = pc[IM_DEPTH_LOG2+1:2];
  assign instr_valid   = (state == RUN);
  assign instr         = instr_valid ? im_rdata : 32'h0;
  assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

  // NOTE: every variable assigned in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    npc_raw = pc_plus4;
    unique case (npc_sel)
      2'b00: npc_raw = pc_plus4;
      2'b01: npc_raw = br_taken ? (pc_plus4 + branch_offset) : pc_plus4;
      2'b10: npc_raw = {pc_plus4[31:28], instr[25:0], 2'b00};
      2'b11: npc_raw = reg_target;
      default: npc_raw = pc_plus4;
    endcase
  end

  // Low address bits are dropped so a misaligned jr target still fetches a whole word.
  assign npc = npc_raw & ~32'd3;

`ifdef FETCH_BOUND_CHECK_EN
  localparam logic [32:0] BOUND_LO = {1'b0, RESET_PC};
  localparam logic [32:0] BOUND_HI = BOUND_LO + (33'd4 << IM_DEPTH_LOG2);
  logic out_of_range;
  assign out_of_range = ({1'b0, npc} < BOUND_LO) || ({1'b0, npc} >= BOUND_HI);
`endif

  always_comb begin
    state_next = state;
    load       = 1'b0;
    fault_set  = 1'b0;
    unique case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (halt) begin
          state_next = HALT;
        end else if (!stall) begin
`ifdef FETCH_BOUND_CHECK_EN
          if (out_of_range) begin
            state_next = HALT;
            fault_set  = 1'b1;
          end else begin
            load = 1'b1;
          end
`else
          load = 1'b1;
`endif
        end
      end
      HALT:    state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      retired <= 32'h0;
    end else begin
      state <= state_next;
      if (load) begin
        pc      <= npc;
        retired <= retired + 32'd1;
      end
    end
  end

`ifdef FETCH_BOUND_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_fault <= 1'b0;
    end else if (fault_set) begin
      fetch_fault <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic        br_taken = 1'b0;
  logic [31:0] reg_target = 32'h0;
  logic [9:0]  im_raddr;
  logic [31:0] im_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired;
`ifdef FETCH_BOUND_CHECK_EN
  logic        fetch_fault;
`endif

  logic [31:0] mem [0:1023];
  assign im_rdata = mem[im_raddr];

  pc_fetch_unit #(.RESET_PC(RESET_PC), .IM_DEPTH_LOG2(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall      (stall),
    .halt       (halt),
    .npc_sel    (npc_sel),
    .br_taken   (br_taken),
    .reg_target (reg_target),
    .im_raddr   (im_raddr),
    .im_rdata   (im_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .retired    (retired)
`ifdef FETCH_BOUND_CHECK_EN
    ,
    .fetch_fault(fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: has the boot cycle elapsed, has the core stopped, where is it.
  bit          m_booted, m_halted, m_fault;
  logic [31:0] m_pc, m_ret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_instr();
    return (m_booted && !m_halted) ? mem[m_pc[11:2]] : 32'h0;
  endfunction

  function automatic logic [31:0] m_npc();
    logic [31:0] seq = m_pc + 32'd4;
    logic [31:0] i   = m_instr();
    int          off;
    off = $signed(i[15:0]);
    off = off * 4;
    case (npc_sel)
      2'b00:   return seq;
      2'b01:   return br_taken ? seq + 32'(off) : seq;
      2'b10:   return {seq[31:28], i[25:0], 2'b00};
      default: return reg_target & ~32'd3;
    endcase
  endfunction

  task automatic m_reset();
    m_booted = 1'b0;
    m_halted = 1'b0;
    m_fault  = 1'b0;
    m_pc     = RESET_PC;
    m_ret    = 32'h0;
  endtask

  task automatic m_advance();
    logic [31:0] nxt;
    if (!m_booted) begin
      m_booted = 1'b1;
    end else if (!m_halted) begin
      if (halt) begin
        m_halted = 1'b1;
      end else if (!stall) begin
        nxt = m_npc();
`ifdef FETCH_BOUND_CHECK_EN
        if (nxt < RESET_PC || nxt >= RESET_PC + 32'd4096) begin
          m_halted = 1'b1;
          m_fault  = 1'b1;
        end else
`endif
        begin
          m_pc  = nxt;
          m_ret = m_ret + 32'd1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("im_raddr", {22'd0, im_raddr}, {22'd0, m_pc[11:2]});
    check("instr_valid", {31'd0, instr_valid}, {31'd0, (m_booted && !m_halted)});
    check("instr", instr, m_instr());
    check("retired", retired, m_ret);
`ifdef FETCH_BOUND_CHECK_EN
    check("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
`endif
  endtask

  // Called at a falling edge: drive inputs, advance the model across the next rising edge, compare.
  task automatic step(input logic s, input logic h, input logic [1:0] sel,
                      input logic b, input logic [31:0] tgt);
    stall      = s;
    halt       = h;
    npc_sel    = sel;
    br_taken   = b;
    reg_target = tgt;
    m_advance();
    @(negedge clk);
    compare_all();
  endtask

  // Asserts reset between edges, checks its immediate effect, releases it at the next falling edge.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[4] = 32'h1000_FFFF;
    mem[8] = 32'h0800_0C40;
    m_reset();

    @(negedge clk);
    do_reset();

    // Sequential fetch from reset, including the boot cycle.
    step(0, 0, 2'b00, 0, 0);
    check("boot_pc", pc, 32'h3000);
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 0, 0);
    check("seq_pc", pc, 32'h300C);
    check("seq_retired", retired, 32'd3);
    check("seq_raddr", {22'd0, im_raddr}, 32'h3);

    // Branch taken back onto itself, then not taken.
    step(0, 0, 2'b00, 0, 0);
    step(0, 0, 2'b01, 1, 0);
    check("br_taken_pc", pc, 32'h3010);
    step(0, 0, 2'b01, 0, 0);
    check("br_not_taken_pc", pc, 32'h3014);

    // Jump and misaligned register target.
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 0, 0);
    step(0, 0, 2'b10, 0, 0);
    check("jump_pc", pc, 32'h3100);
    step(0, 0, 2'b11, 0, 32'h3203);
    check("jr_pc", pc, 32'h3200);

`ifdef FETCH_BOUND_CHECK_EN
    step(0, 0, 2'b11, 0, 32'h4000);
    check("oob_fault", {31'd0, fetch_fault}, 32'd1);
    check("oob_pc", pc, 32'h3200);
    check("oob_valid", {31'd0, instr_valid}, 32'd0);
`else
    step(0, 0, 2'b11, 0, 32'hFFFF_FFFD);
    check("top_pc", pc, 32'hFFFF_FFFC);
    step(0, 0, 2'b00, 0, 0);
    check("wrap_pc", pc, 32'h0);
`endif

    // Stall holds everything; halt wins over stall and is terminal.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 2'b11, 1, $urandom);
    check("stall_pc", pc, 32'h3008);
    check("stall_retired", retired, 32'd2);
    step(1, 1, 2'b00, 0, 0);
    check("halt_valid", {31'd0, instr_valid}, 32'd0);
    check("halt_instr", instr, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 2'($urandom), 1'($urandom), $urandom);
    check("halt_pc", pc, 32'h3008);

    // Reset asserted mid-run.
    do_reset();
    for (int i = 0; i < 17; i++) step(0, 0, 2'b00, 0, 0);
    check("pre_reset_pc", pc, 32'h3040);
    do_reset();
    check("mid_reset_pc", pc, 32'h3000);
    check("mid_reset_retired", retired, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ((m_halted && $urandom_range(3) == 0) || $urandom_range(299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(4) == 0, $urandom_range(99) == 0, 2'($urandom_range(3)),
             1'($urandom),
             ($urandom_range(3) == 0) ? $urandom : RESET_PC + $urandom_range(4095));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
